// File: rtl/rsp_comp_pkg.sv
// Shared types and sizing for the masked-lane compactor.
package rsp_comp_pkg;

  localparam int READ_RAM_WIDTH = 128;
  localparam int NUM            = 8;
  localparam int DATA_WIDTH     = 16;
  localparam int SLOT_W         = DATA_WIDTH;
  localparam int CNT_W          = $clog2(NUM + 1);
  localparam int FILL_W         = $clog2(NUM);

  typedef enum logic {S_RUN, S_FLUSH} comp_state_t;
  typedef logic [DATA_WIDTH-1:0] slot_t;

endpackage

// File: rtl/lane_pack.sv
// Combinational lane packer: squeezes the kept slots of one word to the bottom,
// lowest lane first, and reports how many slots survived.
module lane_pack
  import rsp_comp_pkg::*;
(
  input  logic [READ_RAM_WIDTH-1:0] x,
  input  logic [NUM-1:0]            keep,
  input  logic                      real_mode,
  output slot_t [NUM-1:0]           slots,
  output logic [CNT_W-1:0]          kept
);

  logic [NUM-1:0]   keep_eff;
  logic [CNT_W-1:0] pos;

  // In complex mode a 32-bit lane is a slot pair steered by its even keep bit.
  always_comb begin
    for (int k = 0; k < NUM; k++)
      keep_eff[k] = real_mode ? keep[k] : keep[k - (k % 2)];
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred;
  // blocking assignments are right in combinational code because pos is a running sum.
  always_comb begin
    slots = '0;
    pos   = '0;
    for (int k = 0; k < NUM; k++) begin
      if (keep_eff[k]) begin
        slots[pos[FILL_W-1:0]] = x[k*SLOT_W +: SLOT_W];
        pos = pos + 1'b1;
      end
    end
    kept = pos;
  end

endmodule

// File: rtl/lane_compactor.sv
// Drops unkept lanes and packs survivors densely into full output words with valid/ready.
// Optional feature: define COMPACT_STATS_EN to add the o_frame_slots kept-slot counter.
module lane_compactor
  import rsp_comp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_switch,
  input  logic [READ_RAM_WIDTH-1:0] i_x0,
  input  logic [NUM-1:0]            i_keep,
  input  logic                      i_x0_valid,
  input  logic                      i_last,
  output logic                      o_x0_ready,
  output logic [READ_RAM_WIDTH-1:0] o_y0,
  output logic [CNT_W-1:0]          o_y0_cnt,
  output logic                      o_y0_valid,
  output logic                      o_y0_last,
  input  logic                      i_y0_ready
`ifdef COMPACT_STATS_EN
  ,
  output logic [15:0]               o_frame_slots
`endif
);

  comp_state_t               state_q, state_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  logic [READ_RAM_WIDTH-1:0] buf_q, buf_d;
  logic                      mode_q, mode_d;
  logic                      mid_q, mid_d;
  logic [READ_RAM_WIDTH-1:0] y0_d;
  logic [CNT_W-1:0]          cnt_d;
  logic                      valid_d, last_d;

  logic                        accept, mode_cur, full;
  slot_t [NUM-1:0]             pack_slots;
  logic [READ_RAM_WIDTH-1:0]   pack_flat, buf_masked;
  logic [2*READ_RAM_WIDTH-1:0] joined;
  logic [CNT_W-1:0]            kept, total, rem;

  assign o_x0_ready = (state_q == S_RUN) && (!o_y0_valid || i_y0_ready);
  assign accept     = i_x0_valid && o_x0_ready;
  // The first beat of a frame takes the live mode; later beats reuse the latched one.
  assign mode_cur   = mid_q ? mode_q : i_switch;

  lane_pack u_pack (
    .x         (i_x0),
    .keep      (i_keep),
    .real_mode (mode_cur),
    .slots     (pack_slots),
    .kept      (kept)
  );

  assign pack_flat = pack_slots;

  // Slots at or above fill are stale; mask them so partial words come out zero-padded.
  always_comb begin
    buf_masked = '0;
    for (int k = 0; k < NUM; k++)
      if (FILL_W'(k) < fill_q)
        buf_masked[k*SLOT_W +: SLOT_W] = buf_q[k*SLOT_W +: SLOT_W];
  end

  assign joined = {{READ_RAM_WIDTH{1'b0}}, buf_masked}
                | ({{READ_RAM_WIDTH{1'b0}}, pack_flat} << (32'(fill_q) * SLOT_W));
  assign total  = CNT_W'(fill_q) + kept;
  assign full   = (total >= CNT_W'(NUM));
  assign rem    = full ? total - CNT_W'(NUM) : total;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    mode_d  = mode_q;
    mid_d   = mid_q;
    y0_d    = o_y0;
    cnt_d   = o_y0_cnt;
    valid_d = o_y0_valid;
    last_d  = o_y0_last;

    if (o_y0_valid && i_y0_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    unique case (state_q)
      S_RUN: begin
        if (accept) begin
          if (!mid_q) mode_d = i_switch;
          mid_d  = !i_last;
          fill_d = rem[FILL_W-1:0];
          buf_d  = full ? joined[2*READ_RAM_WIDTH-1:READ_RAM_WIDTH]
                        : joined[READ_RAM_WIDTH-1:0];
          if (full) begin
            y0_d    = joined[READ_RAM_WIDTH-1:0];
            cnt_d   = CNT_W'(NUM);
            valid_d = 1'b1;
            last_d  = i_last && (rem == '0);
          end
          if (i_last && !(full && rem == '0)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // A pending last=1 word is the partial; anything else pending is the full word before it.
        if (o_y0_valid && o_y0_last) begin
          if (i_y0_ready) begin
            fill_d  = '0;
            state_d = S_RUN;
          end
        end else if (!o_y0_valid || i_y0_ready) begin
          y0_d    = buf_masked;
          cnt_d   = CNT_W'(fill_q);
          valid_d = 1'b1;
          last_d  = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      fill_q     <= '0;
      mode_q     <= 1'b1;
      mid_q      <= 1'b0;
      o_y0       <= '0;
      o_y0_cnt   <= '0;
      o_y0_valid <= 1'b0;
      o_y0_last  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      mode_q     <= mode_d;
      mid_q      <= mid_d;
      o_y0       <= y0_d;
      o_y0_cnt   <= cnt_d;
      o_y0_valid <= valid_d;
      o_y0_last  <= last_d;
    end
  end

  // NOTE: the slot buffer is data storage with no reset; fill_q alone says which slots are live.
  always_ff @(posedge clk) buf_q <= buf_d;

`ifdef COMPACT_STATS_EN
  logic [15:0] acc_q;
  logic [16:0] frame_sum;
  logic [15:0] frame_sat;

  assign frame_sum = (mid_q ? {1'b0, acc_q} : 17'd0) + 17'(kept);
  assign frame_sat = frame_sum[16] ? 16'hFFFF : frame_sum[15:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q         <= '0;
      o_frame_slots <= '0;
    end else if (accept) begin
      if (i_last) begin
        acc_q         <= '0;
        o_frame_slots <= frame_sat;
      end else begin
        acc_q         <= frame_sat;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lane_compactor.sv
// Directed self-checking bench for lane_compactor with hand-computed expected words.
module tb_lane_compactor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_switch;
  logic [127:0] i_x0;
  logic [7:0]   i_keep;
  logic         i_x0_valid;
  logic         i_last;
  logic         o_x0_ready;
  logic [127:0] o_y0;
  logic [3:0]   o_y0_cnt;
  logic         o_y0_valid;
  logic         o_y0_last;
  logic         i_y0_ready;
`ifdef COMPACT_STATS_EN
  logic [15:0]  o_frame_slots;
`endif

  lane_compactor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_switch   (i_switch),
    .i_x0       (i_x0),
    .i_keep     (i_keep),
    .i_x0_valid (i_x0_valid),
    .i_last     (i_last),
    .o_x0_ready (o_x0_ready),
    .o_y0       (o_y0),
    .o_y0_cnt   (o_y0_cnt),
    .o_y0_valid (o_y0_valid),
    .o_y0_last  (o_y0_last),
    .i_y0_ready (i_y0_ready)
`ifdef COMPACT_STATS_EN
    ,
    .o_frame_slots (o_frame_slots)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] XA = 128'h1107_1106_1105_1104_1103_1102_1101_1100;
  localparam logic [127:0] XB = 128'h2207_2206_2205_2204_2203_2202_2201_2200;
  localparam logic [127:0] XC = 128'h3307_3306_3305_3304_3303_3302_3301_3300;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   c;
    logic         l;
  } word_t;

  word_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Output handshakes are sampled at negedge; inputs only change just after posedge.
  always @(negedge clk)
    if (rst_n && o_y0_valid && i_y0_ready)
      q.push_back('{d: o_y0, c: o_y0_cnt, l: o_y0_last});

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the beat.
  task automatic send(input logic [127:0] x, input logic [7:0] k, input logic sw, input logic last);
    logic acc;
    int   n;
    n          = 0;
    acc        = 1'b0;
    i_x0       = x;
    i_keep     = k;
    i_switch   = sw;
    i_last     = last;
    i_x0_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = o_x0_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
    i_x0_valid = 1'b0;
    i_last     = 1'b0;
  endtask

  task automatic settle(input string tag, input int n);
    repeat (8) @(posedge clk);
    #1;
    check(tag, q.size(), n);
  endtask

  task automatic expect_word(input string tag, input logic [127:0] d, input int c, input logic l);
    word_t w;
    if (q.size() == 0) begin
      check({tag, "_present"}, 0, 1);
      return;
    end
    w = q.pop_front();
    check({tag, "_data"}, w.d, d);
    check({tag, "_cnt"},  w.c, c);
    check({tag, "_last"}, w.l, l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    i_switch   = 1'b1;
    i_x0       = '0;
    i_keep     = '0;
    i_x0_valid = 1'b0;
    i_last     = 1'b0;
    i_y0_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_y0_valid, 0);
    check("rst_data",  o_y0, 0);
    check("rst_cnt",   o_y0_cnt, 0);
    check("rst_last",  o_y0_last, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", o_x0_ready, 1);

    // 1: real pass-through, two full beats
    send(XA, 8'hFF, 1'b1, 1'b0);
    check("t1_latency", o_y0_valid, 1);
    send(XB, 8'hFF, 1'b1, 1'b1);
    settle("t1_words", 2);
    expect_word("t1_w0", XA, 8, 1'b0);
    expect_word("t1_w1", XB, 8, 1'b1);

    // 2: sparse real keep, one full word plus a padded partial
    send(XA, 8'b1010_0101, 1'b1, 1'b0);
    send(XB, 8'b1010_0101, 1'b1, 1'b0);
    send(XC, 8'b1010_0101, 1'b1, 1'b1);
    settle("t2_words", 2);
    expect_word("t2_w0", 128'h2207_2205_2202_2200_1107_1105_1102_1100, 8, 1'b0);
    expect_word("t2_w1", 128'h0000_0000_0000_0000_3307_3305_3302_3300, 4, 1'b1);
`ifdef COMPACT_STATS_EN
    check("t2_stats", o_frame_slots, 12);
`endif

    // 3: complex mode slot pairs
    send(XA, 8'b0000_0011, 1'b0, 1'b0);
    send(XB, 8'b1100_0000, 1'b0, 1'b1);
    settle("t3_words", 1);
    expect_word("t3_w0", 128'h0000_0000_0000_0000_2207_2206_1101_1100, 4, 1'b1);

    // 3b: odd keep bits ignored in complex mode; mid-frame i_switch change ignored
    send(XA, 8'b1000_0001, 1'b0, 1'b0);
    send(XB, 8'b0000_0100, 1'b1, 1'b1);
    settle("t3b_words", 1);
    expect_word("t3b_w0", 128'h0000_0000_0000_0000_2203_2202_1101_1100, 4, 1'b1);

    // 4: backpressure holds the output word and stalls the input
    i_y0_ready = 1'b0;
    send(XA, 8'hFF, 1'b1, 1'b0);
    i_x0       = XB;
    i_keep     = 8'hFF;
    i_last     = 1'b1;
    i_x0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_data",  o_y0, XA);
      check("t4_hold_ready", o_x0_ready, 0);
    end
    @(posedge clk);
    #1;
    i_y0_ready = 1'b1;
    send(XB, 8'hFF, 1'b1, 1'b1);
    settle("t4_words", 2);
    expect_word("t4_w0", XA, 8, 1'b0);
    expect_word("t4_w1", XB, 8, 1'b1);

    // 5: empty frame
    send(XC, 8'h00, 1'b1, 1'b1);
    settle("t5_words", 1);
    expect_word("t5_w0", 128'h0, 0, 1'b1);
`ifdef COMPACT_STATS_EN
    check("t5_stats", o_frame_slots, 0);
`endif

    // 6: reset mid-frame with fill=5 and a word pending
    i_y0_ready = 1'b0;
    send(XA, 8'b0001_1111, 1'b1, 1'b0);
    send(XB, 8'hFF, 1'b1, 1'b0);
    check("t6_pre_data", o_y0, 128'h2202_2201_2200_1104_1103_1102_1101_1100);
    check("t6_pre_cnt",  o_y0_cnt, 8);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rst_valid", o_y0_valid, 0);
    check("t6_rst_data",  o_y0, 0);
    check("t6_rst_cnt",   o_y0_cnt, 0);
    check("t6_rst_last",  o_y0_last, 0);
    check("t6_rst_ready", o_x0_ready, 1);
    rst_n      = 1'b1;
    i_y0_ready = 1'b1;
    q.delete();
    send(XC, 8'hFF, 1'b1, 1'b1);
    settle("t6_words", 1);
    expect_word("t6_w0", XC, 8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
